// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive (uart_get) and transmit
// (uart_put) sides: default bit timing, byte type and receiver state type.
package uart_pkg;

  // 12 MHz system clock / 115200 baud
  localparam int unsigned CLKS_PER_BIT_DEF = 104;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  // Receiver frame states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_get_if.sv
// Receive byte stream: valid/ready handshake from the UART receiver to the
// consumer. The receiver is the master (drives data/valid).
interface uart_get_if;
  import uart_pkg::*;

  byte_t out_data;
  logic  out_valid;
  logic  out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small first-in first-out byte buffer between the UART receiver and its
// consumer. A push into a full buffer is accepted only when a pop happens in
// the same cycle; a pop from an empty buffer is ignored.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  byte_t push_data,
  input  logic  pop,
  output byte_t head_data,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  byte_t         mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A full buffer can still take a byte when the head leaves in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head byte is forced to zero while the buffer holds nothing
  assign head_data = empty ? '0 : mem[rptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^AW)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only observed through head_data when non-empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/uart_get.sv
// UART receiver: 8 data bits, LSB first, one stop bit, no parity.
// The RX line is synchronised, the start bit is confirmed at mid-bit, each
// data bit and the stop bit are sampled one bit period apart, and completed
// bytes are queued in a small FIFO for the consumer.
module uart_get
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart,
  uart_get_if.master        rxq,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync;
  logic          rx_s;

  rx_state_t     state;
  rx_state_t     state_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx;
  logic [2:0]    idx_d;
  byte_t         shreg;
  byte_t         sh_d;
  logic          tick;
  logic          push;
  logic          fe_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[0], uart};
  end

  assign rx_s = sync[1];
  assign tick = (cnt == '0);

  // Receiver state, bit timer, bit index and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shreg <= sh_d;
    end
  end

  // Next-state logic; the bit timer free-runs down to zero and is reloaded
  // on each sampling point
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    sh_d    = shreg;
    push    = 1'b0;
    fe_d    = 1'b0;

    if (!tick) cnt_d = cnt - CW'(1);

    unique case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d = ST_DATA;
            cnt_d   = FULL_LOAD;
            idx_d   = '0;
          end else begin
            // line went back high before mid-start: treat as a glitch
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          sh_d[idx] = rx_s;
          cnt_d     = FULL_LOAD;
          if (idx == 3'd7) state_d = ST_STOP;
          else             idx_d   = idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // a low stop bit may be a break; hold off until the line is idle
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop  = rxq.out_valid & rxq.out_ready;
  assign busy = (state != ST_IDLE);

  // Error pulses, reported the cycle after the stop-bit sampling point
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_d;
      overrun   <= push & fifo_full & ~pop;
    end
  end

  assign rxq.out_valid = ~fifo_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .head_data (rxq.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_get.sv
// Bench for uart_get: directed serial frames, a frame-level reference model
// (byte queue plus scheduled stop-bit events) compared every cycle, and
// hand-computed literal checks for latency, ordering and reset behaviour.
module tb_uart_get;
  import uart_pkg::*;

  localparam int unsigned CPB   = 104;
  localparam int unsigned DEPTH = 4;
  // Edges from driving the start bit low to the stop-bit sampling edge:
  // 2 synchroniser + 1 detect + 52 half bit + 8*104 data + 104 stop
  localparam int unsigned PUSH_LAT = 991;

  logic clk = 1'b0;
  logic rst;
  logic uart;
  logic frame_err;
  logic overrun;
  logic busy;

  uart_get_if bus ();

  uart_get #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart      (uart),
    .rxq       (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned at;
    bit          fe;
    byte_t       d;
  } ev_t;

  byte_t       mq[$];
  ev_t         evq[$];
  bit          exp_fe = 1'b0;
  bit          exp_ov = 1'b0;
  int unsigned cyc = 0;
  int unsigned fe_seen = 0;
  int unsigned ov_seen = 0;
  byte_t       got[$];

  always @(posedge clk or posedge rst) begin
    ev_t e;
    if (rst) begin
      mq.delete();
      evq.delete();
      exp_fe = 1'b0;
      exp_ov = 1'b0;
    end else begin
      cyc++;
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
      while (evq.size() != 0 && evq[0].at == cyc) begin
        e = evq.pop_front();
        if (e.fe)                 exp_fe = 1'b1;
        else if (mq.size() == DEPTH) exp_ov = 1'b1;
        else                      mq.push_back(e.d);
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", bus.out_valid, mq.size() != 0);
    check("out_data", bus.out_data, (mq.size() != 0) ? mq[0] : 8'h00);
    check("frame_err", frame_err, exp_fe);
    check("overrun", overrun, exp_ov);
    if (frame_err) fe_seen++;
    if (overrun)   ov_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_frame(input byte_t b, input bit stop_ok, input int unsigned stop_hold);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    @(posedge clk); #1;
    evq.push_back('{at: cyc + PUSH_LAT, fe: !stop_ok, d: b});
    for (int i = 0; i < 9; i++) begin
      uart = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart = bits[9];
    repeat (stop_hold) @(posedge clk);
    #1;
    uart = 1'b1;
  endtask

  task automatic drain(input int unsigned n);
    got.delete();
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (n) begin
      @(negedge clk);
      got.push_back(bus.out_data);
      @(posedge clk);
    end
    #1;
    bus.out_ready = 1'b0;
  endtask

  int unsigned ov0;
  int unsigned fe0;
  logic [9:0]  pbits;

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    uart = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_data", bus.out_data, 8'h00);
    check("rst_fe", frame_err, 1'b0);
    check("rst_ov", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // A5, consumer not ready; pin the push latency
    fork
      send_frame(8'hA5, 1'b1, CPB);
      begin
        @(posedge clk);
        repeat (PUSH_LAT - 1) @(posedge clk);
        @(negedge clk);
        check("lat_before", bus.out_valid, 1'b0);
        @(negedge clk);
        check("lat_after", bus.out_valid, 1'b1);
      end
    join
    check("a5_valid", bus.out_valid, 1'b1);
    check("a5_data", bus.out_data, 8'hA5);
    check("a5_busy", busy, 1'b0);
    drain(1);
    check("a5_pop", got[0], 8'hA5);

    // Short low glitch: rejected at mid-start
    @(posedge clk); #1;
    uart = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("glitch_busy_hi", busy, 1'b1);
    repeat (10) @(posedge clk); #1;
    uart = 1'b1;
    repeat (40) @(posedge clk); #1;
    check("glitch_busy_lo", busy, 1'b0);
    check("glitch_nopush", bus.out_valid, 1'b0);

    // 3C with a long low stop bit, then 5A
    fe0 = fe_seen;
    fork
      send_frame(8'h3C, 1'b0, 300);
      begin
        @(posedge clk);
        repeat (1100) @(posedge clk);
        #1;
        check("wait_idle_busy", busy, 1'b1);
      end
    join
    repeat (10) @(posedge clk); #1;
    check("fe_busy_lo", busy, 1'b0);
    check("fe_count", fe_seen - fe0, 1);
    check("fe_empty", bus.out_valid, 1'b0);
    repeat (20) @(posedge clk);
    send_frame(8'h5A, 1'b1, CPB);
    check("5a_data", bus.out_data, 8'h5A);
    drain(1);
    check("5a_pop", got[0], 8'h5A);

    // Five bytes into a four-entry buffer
    ov0 = ov_seen;
    for (int i = 1; i <= 5; i++) send_frame(byte_t'(i), 1'b1, CPB);
    check("ov_count", ov_seen - ov0, 1);
    drain(4);
    for (int i = 0; i < 4; i++) check("ov_order", got[i], i + 1);
    @(negedge clk);
    check("ov_drained", bus.out_valid, 1'b0);

    // Full buffer, pop coincides with push of 77
    send_frame(8'h11, 1'b1, CPB);
    send_frame(8'h22, 1'b1, CPB);
    send_frame(8'h33, 1'b1, CPB);
    send_frame(8'h44, 1'b1, CPB);
    ov0 = ov_seen;
    fork
      send_frame(8'h77, 1'b1, CPB);
      begin
        @(posedge clk);
        repeat (PUSH_LAT - 1) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
      end
    join
    check("simul_noov", ov_seen - ov0, 0);
    drain(4);
    check("simul_0", got[0], 8'h22);
    check("simul_1", got[1], 8'h33);
    check("simul_2", got[2], 8'h44);
    check("simul_3", got[3], 8'h77);

    // Reset during bit 4 of C3 with a byte waiting
    send_frame(8'h99, 1'b1, CPB);
    pbits = {1'b1, 8'hC3, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      uart = pbits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart = pbits[5];
    repeat (52) @(posedge clk); #1;
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", bus.out_valid, 1'b0);
    check("mid_rst_data", bus.out_data, 8'h00);
    check("mid_rst_fe", frame_err, 1'b0);
    check("mid_rst_ov", overrun, 1'b0);
    uart = 1'b1;
    repeat (5) @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    send_frame(8'h81, 1'b1, CPB);
    check("81_valid", bus.out_valid, 1'b1);
    check("81_data", bus.out_data, 8'h81);
    drain(1);
    check("81_pop", got[0], 8'h81);
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_get.md
UART_GET -- requirements
Module: uart_get

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, clocks per bit period (12 MHz / 115200 baud).
REQ-002 Parameter FIFO_DEPTH, default 4, receive byte buffer entries, power of two >= 2.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 uart  input  1  serial RX line, asynchronous to clk, idle high.
REQ-006 out_data  output  8  byte at FIFO head; 8'h00 when FIFO empty.
REQ-007 out_valid  output  1  FIFO non-empty.
REQ-008 out_ready  input  1  consumer accept; pop occurs when out_valid & out_ready.
REQ-009 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse, completed byte dropped because FIFO full.
REQ-011 busy  output  1  high whenever receive FSM is not IDLE.

Function
REQ-012 uart passes through a 2-flop synchronizer (reset value 1) before any use; all timing below refers to the synchronized line (rx_s).
REQ-013 FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: rx_s==0 -> START, bit counter loaded CLKS_PER_BIT/2-1 (51).
REQ-015 Bit counter decrements each cycle while non-zero; "tick" is the cycle it equals 0.
REQ-016 START tick: rx_s==0 -> DATA, counter reloaded CLKS_PER_BIT-1, bit index 0; rx_s==1 -> IDLE (glitch rejected, nothing reported).
REQ-017 DATA tick: shift register bit[index] <= rx_s (LSB first); index 7 -> STOP, else index+1; counter reloaded CLKS_PER_BIT-1.
REQ-018 STOP tick, rx_s==1: byte pushed to FIFO (or overrun per REQ-021), -> IDLE.
REQ-019 STOP tick, rx_s==0: frame_err pulses next cycle, byte discarded, -> WAIT_IDLE.
REQ-020 WAIT_IDLE: stays until rx_s==1, then -> IDLE; no start detected while in WAIT_IDLE.
REQ-021 Push when full and no pop same cycle: byte dropped, overrun pulses next cycle, FIFO contents unchanged.
REQ-022 Push and pop same cycle while full: both succeed, no overrun, count unchanged.
REQ-023 Push and pop same cycle while empty: pop ignored (out_valid low), push succeeds.
REQ-024 Latency: out_valid rises the cycle after the STOP tick when FIFO was empty.
REQ-025 FIFO order strictly first-in first-out; read/write pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-026 out_data/out_valid hold stable while out_valid & ~out_ready.
REQ-027 frame_err and overrun never high two consecutive cycles for one event; both may not occur for the same byte.

Reset
REQ-028 rst asserts asynchronously: FSM IDLE, counter 0, index 0, shift register 0, FIFO empty, pointers 0, synchronizer flops 1.
REQ-029 Reset values: out_data 0, out_valid 0, frame_err 0, overrun 0, busy 0.
REQ-030 Reset mid-byte discards the partial byte; first falling edge after deassertion starts a fresh frame.

Structure
REQ-031 Shared package uart_pkg holds CLKS_PER_BIT default, the FSM state typedef, and byte width 8 (also used by uart_put-side logic).
REQ-032 FIFO is a sub-module uart_rx_fifo (push/pop/full/empty/data, async active-high reset); FSM and synchronizer stay in uart_get.

Verification
REQ-033 Send 8'hA5 at 104 clk/bit, out_ready=0 -> out_valid=1, out_data=8'hA5, frame_err=0, overrun=0.
REQ-034 Drive uart low 20 cycles then high -> no push, FSM back in IDLE within 52 cycles, busy low after.
REQ-035 Send 8'h3C with stop bit 0 held low 300 cycles -> one frame_err pulse, FIFO empty, next byte 8'h5A after line high received correctly.
REQ-036 Send 8'h01..8'h05 back-to-back, out_ready=0 -> one overrun pulse on 5th byte; pops yield 01,02,03,04 then out_valid=0.
REQ-037 FIFO full, out_ready=1 held so pop coincides with STOP-tick push of 8'h77 -> no overrun, 8'h77 read last.
REQ-038 Assert rst during bit 4 of 8'hC3 -> all outputs 0 immediately; subsequent 8'h81 received as 8'h81.
